// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package adder_seq_ctrl_pkg;

    localparam int unsigned NIBBLE        = 4;
    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned NIBBLE_COUNT  = DEFAULT_WIDTH / NIBBLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble steps needed for an operand of the given width.
    function automatic int unsigned nibble_count(input int unsigned width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Requester/consumer bundle of the adder controller.
interface adder_seq_ctrl_if
    import adder_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/adder_seq_ctrl_nibble_adder.sv
// 4-bit combinational adder shared by both requesters.
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] total;

    // Full 4-bit add with carry in/out.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        s     = total[3:0];
        cout  = total[4];
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Two-requester arbiter that time-shares one nibble adder, producing a
// WIDTH-bit sum one nibble per cycle, LSB first.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_seq_ctrl_if.slave bus
);

    localparam int unsigned NIBBLES = nibble_count(WIDTH);
    localparam int unsigned CNT_W   = $clog2(NIBBLES + 1);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
        $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t           state;
    logic             rr_q;
    logic             rdy0_q;
    logic             rdy1_q;
    logic             carry_q;
    logic             id_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [NIBBLE-1:0] nib_s;
    logic             nib_cout;
    logic             pick0;
    logic             pick1;

    // Ready is a registered grant qualified by the live valid, so it is
    // never high without a request (including while held in reset).
    assign bus.req0_ready = rdy0_q & bus.req0_valid;
    assign bus.req1_ready = rdy1_q & bus.req1_valid;
    assign bus.busy       = (state != IDLE);

    // Round-robin pick between the current requests.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            pick0 = ~rr_q;
            pick1 = rr_q;
        end else begin
            pick0 = bus.req0_valid;
            pick1 = bus.req1_valid;
        end
    end

    nibble_adder u_nibble_adder (
        .a    (a_q[NIBBLE-1:0]),
        .b    (b_q[NIBBLE-1:0]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // Control FSM and datapath. Operands shift right one nibble per RUN
    // cycle while the sum shifts in from the top; the extra RUN cycle at
    // cnt == NIBBLES publishes the finished result into the rsp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_q         <= 1'b0;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_id    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req0_ready || bus.req1_ready) begin
                        state  <= RUN;
                        rdy0_q <= 1'b0;
                        rdy1_q <= 1'b0;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        if (bus.req0_ready) begin
                            a_q     <= bus.req0_a;
                            b_q     <= bus.req0_b;
                            carry_q <= bus.req0_cin;
                            id_q    <= 1'b0;
                            rr_q    <= 1'b1;
                        end else begin
                            a_q     <= bus.req1_a;
                            b_q     <= bus.req1_b;
                            carry_q <= bus.req1_cin;
                            id_q    <= 1'b1;
                            rr_q    <= 1'b0;
                        end
                    end else begin
                        rdy0_q <= pick0;
                        rdy1_q <= pick1;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(NIBBLES)) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_sum   <= acc_q;
                        bus.rsp_cout  <= carry_q;
                        bus.rsp_id    <= id_q;
                    end else begin
                        acc_q   <= {nib_s, acc_q[WIDTH-1:NIBBLE]};
                        a_q     <= a_q >> NIBBLE;
                        b_q     <= b_q >> NIBBLE;
                        carry_q <= nib_cout;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl.
module tb_adder_seq_ctrl;
    import adder_seq_ctrl_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.WIDTH(W)) bus ();

    adder_seq_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    int unsigned grant_order[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned acc_edge = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        exp_t       e;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.id   = id[0];
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on accept, compare while a response is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.req0_ready || bus.req1_ready)
                check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.busy)
                check("ready_busy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back(model(0, bus.req0_a, bus.req0_b, bus.req0_cin));
                grant_order.push_back(0);
                acc_edge = cyc + 1;
            end else if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back(model(1, bus.req1_a, bus.req1_b, bus.req1_cin));
                grant_order.push_back(1);
                acc_edge = cyc + 1;
            end
            if (bus.rsp_valid) begin
                check("valid_busy", 32'(bus.busy), 32'd1);
                if (!prev_valid)
                    check("latency", cyc - acc_edge, 32'd5);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_sum", 32'(bus.rsp_sum), 32'(sb[0].sum));
                    check("rsp_cout", 32'(bus.rsp_cout), 32'(sb[0].cout));
                    check("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
                    if (bus.rsp_ready)
                        void'(sb.pop_front());
                end
            end
            prev_valid = bus.rsp_valid;
        end
    end

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if ((id == 0) ? bus.req0_ready : bus.req1_ready)
                done = 1'b1;
        end
        if (!done)
            check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb.size() != 0 || bus.busy); i++)
            @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_sum"}, 32'(bus.rsp_sum), 32'd0);
        check({tag, "_rsp_cout"}, 32'(bus.rsp_cout), 32'd0);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ready"}, {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        bit got_valid;

        // Both requesters valid from reset: contention case.
        bus.rsp_ready  = 1'b1;
        bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_a = 16'h8000; bus.req1_b = 16'h8000; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        fork
            issue(0, 16'h0001, 16'h0001, 1'b0);
            issue(1, 16'h8000, 16'h8000, 1'b0);
        join
        drain();
        fork
            issue(0, 16'h1357, 16'h2468, 1'b1);
            issue(1, 16'hC0DE, 16'h4F21, 1'b0);
        join
        drain();
        check("grant_count", 32'(grant_order.size()), 32'd4);
        if (grant_order.size() == 4) begin
            check("grant0", grant_order[0], 32'd0);
            check("grant1", grant_order[1], 32'd1);
            check("grant2", grant_order[2], 32'd0);
            check("grant3", grant_order[3], 32'd1);
        end

        // Directed sums.
        issue(0, 16'h1234, 16'h4321, 1'b0); drain();
        issue(1, 16'hFFFF, 16'h0001, 1'b0); drain();
        issue(0, 16'h7FFF, 16'h0000, 1'b1); drain();

        // Backpressure with the other requester waiting.
        bus.rsp_ready = 1'b0;
        issue(0, 16'hABCD, 16'h1111, 1'b1);
        bus.req1_a = 16'h0F0F; bus.req1_b = 16'h00F1; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        got_valid = 1'b0;
        for (int i = 0; i < 50 && !got_valid; i++) begin
            @(negedge clk);
            got_valid = bus.rsp_valid;
        end
        check("bp_wait", 32'(got_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", 32'(bus.rsp_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", 32'(bus.busy), 32'd0);
        check("bp_valid_low", 32'(bus.rsp_valid), 32'd0);
        issue(1, 16'h0F0F, 16'h00F1, 1'b0);
        drain();

        // Reset in the middle of RUN, after nibble 1.
        issue(0, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("post_reset_quiet", seen, 32'd0);
        issue(0, 16'h00FF, 16'h0001, 1'b0);
        drain();

        // Random traffic, alternating requesters.
        for (int i = 0; i < 8; i++) begin
            issue(i % 2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            drain();
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
